// File: rtl/life_pkg.sv
// Shared definitions for the Game-of-Life grid engine.
//  - life_state_e : step sequencer states (IDLE / STEP / FIN)
//  - B3_MASK / S23_MASK : classic Conway birth/survive rule masks
//  - count_live() : population count of the eight neighbour bits
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_FIN  = 2'd2
  } life_state_e;

  localparam logic [8:0] B3_MASK  = 9'b000001000;
  localparam logic [8:0] S23_MASK = 9'b000001100;

  // Number of live cells among eight neighbours (0..8).
  function automatic logic [3:0] count_live(input logic [7:0] nb);
    logic [3:0] sum;
    sum = 4'd0;
    for (int i = 0; i < 8; i++) begin
      sum = sum + {3'd0, nb[i]};
    end
    return sum;
  endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state rule for a single cell.
//  up   : three cells of the row above (left, centre, right in any order)
//  mid  : three cells of the own row; mid[1] is the cell itself
//  down : three cells of the row below
//  next : cell value in the next generation
// A live cell survives when SURVIVE_MASK[n] is set, a dead cell is born when
// BIRTH_MASK[n] is set, n being the live-neighbour count.
module life_cell_rule
  import life_pkg::*;
#(
  parameter logic [8:0] BIRTH_MASK   = B3_MASK,
  parameter logic [8:0] SURVIVE_MASK = S23_MASK
) (
  input  logic [2:0] up,
  input  logic [2:0] mid,
  input  logic [2:0] down,
  output logic       next
);

  logic [3:0] n_s;

  assign n_s  = count_live({up, mid[2], mid[0], down});
  assign next = mid[1] ? SURVIVE_MASK[n_s] : BIRTH_MASK[n_s];

endmodule

// File: rtl/life_grid_engine.sv
// Game-of-Life generation engine with in-place, one-row-per-clock update.
//  clk, rst_n                  : clock, asynchronous active-low reset
//  wr_en, wr_row, wr_data      : row write, honoured only while idle
//  rd_row, rd_data             : registered row read (1-cycle latency)
//  start                       : begin one generation (idle only)
//  busy, done                  : step in progress / 1-cycle completion pulse
//  still                       : last completed generation changed nothing
//  generation                  : completed generations since reset
// Rows are overwritten as they are computed, so the old copy of the row above
// is kept in prev_row_r and the old row 0 in row0_save_r (needed by the last
// row when the grid wraps).
module life_grid_engine
  import life_pkg::*;
#(
  parameter int          GRID_W       = 16,
  parameter int          GRID_H       = 16,
  parameter int          TORUS        = 1,
  parameter logic [8:0]  BIRTH_MASK   = B3_MASK,
  parameter logic [8:0]  SURVIVE_MASK = S23_MASK,
  parameter int          GEN_W        = 16,
  localparam int         RW           = $clog2(GRID_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [RW-1:0]     wr_row,
  input  logic [GRID_W-1:0] wr_data,
  input  logic [RW-1:0]     rd_row,
  output logic [GRID_W-1:0] rd_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              still,
  output logic [GEN_W-1:0]  generation
);

  localparam logic [RW:0]   H_LIM    = (RW+1)'(GRID_H);
  localparam logic [RW-1:0] LAST_ROW = RW'(GRID_H - 1);

  life_state_e       state_r, state_nxt_s;
  logic [GRID_W-1:0] grid_r [GRID_H];
  logic [GRID_W-1:0] prev_row_r, row0_save_r, rd_data_r;
  logic [RW-1:0]     row_r;
  logic              changed_r, busy_r, done_r, still_r;
  logic [GEN_W-1:0]  gen_r;
  logic [GRID_W-1:0] up_row_s, mid_row_s, down_row_s, new_row_s;
  logic [GRID_W+1:0] up_ext_s, mid_ext_s, down_ext_s;
  logic              last_row_s, wr_ok_s, rd_ok_s, changed_s, busy_nxt_s, done_nxt_s;

  // Pad a row with its left/right neighbours: wrapped columns or dead border.
  function automatic logic [GRID_W+1:0] extend(input logic [GRID_W-1:0] row);
    if (TORUS != 0) begin
      return {row[0], row, row[GRID_W-1]};
    end else begin
      return {1'b0, row, 1'b0};
    end
  endfunction

  assign last_row_s = (row_r == LAST_ROW);
  assign wr_ok_s    = ({1'b0, wr_row} < H_LIM);
  assign rd_ok_s    = ({1'b0, rd_row} < H_LIM);

  // Neighbour rows for the active row, all taken from the previous generation.
  always_comb begin
    mid_row_s = grid_r[row_r];
    if (row_r == '0) begin
      up_row_s = (TORUS != 0) ? grid_r[GRID_H-1] : '0;
    end else begin
      up_row_s = prev_row_r;
    end
    if (last_row_s) begin
      down_row_s = (TORUS != 0) ? row0_save_r : '0;
    end else begin
      down_row_s = grid_r[row_r + RW'(1)];
    end
  end

  assign up_ext_s   = extend(up_row_s);
  assign mid_ext_s  = extend(mid_row_s);
  assign down_ext_s = extend(down_row_s);

  for (genvar c = 0; c < GRID_W; c++) begin : g_cell
    life_cell_rule #(
      .BIRTH_MASK  (BIRTH_MASK),
      .SURVIVE_MASK(SURVIVE_MASK)
    ) u_rule (
      .up  (up_ext_s[c+2:c]),
      .mid (mid_ext_s[c+2:c]),
      .down(down_ext_s[c+2:c]),
      .next(new_row_s[c])
    );
  end

  assign changed_s = changed_r | (new_row_s != mid_row_s);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_STEP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (last_row_s) begin
          state_nxt_s = ST_FIN;
        end else begin
          state_nxt_s = ST_STEP;
        end
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded from the upcoming state so they can be registered.
  always_comb begin
    busy_nxt_s = (state_nxt_s == ST_STEP);
    done_nxt_s = (state_nxt_s == ST_FIN);
  end

  // Row sequencing, saved old rows, change tracking and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r       <= '0;
      prev_row_r  <= '0;
      row0_save_r <= '0;
      changed_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      still_r     <= 1'b0;
      gen_r       <= '0;
    end else begin
      busy_r <= busy_nxt_s;
      done_r <= done_nxt_s;
      if (state_r == ST_STEP) begin
        row_r      <= last_row_s ? '0 : row_r + RW'(1);
        prev_row_r <= mid_row_s;
        changed_r  <= changed_s;
        if (row_r == '0) begin
          row0_save_r <= mid_row_s;
        end
        if (last_row_s) begin
          still_r <= ~changed_s;
          gen_r   <= gen_r + GEN_W'(1);
        end
      end else begin
        row_r     <= '0;
        changed_r <= 1'b0;
      end
    end
  end

  // Grid storage: step write-back has priority; host writes only while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GRID_H; i++) begin
        grid_r[i] <= '0;
      end
    end else if (state_r == ST_STEP) begin
      grid_r[row_r] <= new_row_s;
    end else if ((state_r == ST_IDLE) && wr_en && wr_ok_s) begin
      grid_r[wr_row] <= wr_data;
    end
  end

  // Registered read port; indices beyond the grid read as dead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else begin
      rd_data_r <= rd_ok_s ? grid_r[rd_row] : '0;
    end
  end

  assign rd_data    = rd_data_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign still      = still_r;
  assign generation = gen_r;

endmodule

// File: tb/tb_life_grid_engine.sv
// Self-checking bench for life_grid_engine. Two instances share all inputs:
//  u_a : 8x6 torus, B3/S23
//  u_b : 8x6 dead border, HighLife B36/S23
// A behavioural Life model (plain neighbour counting) predicts every grid.
module tb_life_grid_engine;

  localparam int         W    = 8;
  localparam int         H    = 6;
  localparam int         RW   = 3;
  localparam int         GW   = 16;
  localparam logic [8:0] C_B  = 9'b000001000;
  localparam logic [8:0] C_S  = 9'b000001100;
  localparam logic [8:0] HL_B = 9'b001001000;

  typedef logic [H-1:0][W-1:0] grid_t;

  logic          clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, start = 1'b0;
  logic [RW-1:0] wr_row = '0, rd_row = '0;
  logic [W-1:0]  wr_data = '0;
  logic [W-1:0]  rd_data_a, rd_data_b;
  logic          busy_a, busy_b, done_a, done_b, still_a, still_b;
  logic [GW-1:0] gen_a, gen_b;

  int    vectors = 0, miscompares = 0, gen_exp = 0;
  grid_t model_a = '0, model_b = '0;

  always #5 clk = ~clk;

  life_grid_engine #(.GRID_W(W), .GRID_H(H), .TORUS(1), .BIRTH_MASK(C_B),
                     .SURVIVE_MASK(C_S), .GEN_W(GW)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .rd_row(rd_row), .rd_data(rd_data_a), .start(start), .busy(busy_a),
    .done(done_a), .still(still_a), .generation(gen_a));

  life_grid_engine #(.GRID_W(W), .GRID_H(H), .TORUS(0), .BIRTH_MASK(HL_B),
                     .SURVIVE_MASK(C_S), .GEN_W(GW)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .rd_row(rd_row), .rd_data(rd_data_b), .start(start), .busy(busy_b),
    .done(done_b), .still(still_b), .generation(gen_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic cell_at(grid_t g, int r, int c, bit torus);
    if (torus) begin
      return g[(r + H) % H][(c + W) % W];
    end else if (r < 0 || r >= H || c < 0 || c >= W) begin
      return 1'b0;
    end else begin
      return g[r][c];
    end
  endfunction

  function automatic grid_t life_next(grid_t g, bit torus, logic [8:0] bm, logic [8:0] sm);
    grid_t n;
    int    cnt;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0) cnt += int'(cell_at(g, r + dr, c + dc, torus));
        n[r][c] = g[r][c] ? sm[cnt] : bm[cnt];
      end
    end
    return n;
  endfunction

  task automatic write_row(input int r, input logic [W-1:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_row = RW'(r); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (r < H) begin
      model_a[r] = d; model_b[r] = d;
    end
  endtask

  task automatic read_row(input int r, output logic [W-1:0] a, output logic [W-1:0] b);
    @(negedge clk);
    rd_row = RW'(r);
    @(posedge clk); #1;
    a = rd_data_a; b = rd_data_b;
  endtask

  task automatic check_grid(input string tag);
    logic [W-1:0] a, b;
    for (int r = 0; r < H; r++) begin
      read_row(r, a, b);
      chk($sformatf("%s_a_row%0d", tag, r), 32'(a), 32'(model_a[r]));
      chk($sformatf("%s_b_row%0d", tag, r), 32'(b), 32'(model_b[r]));
    end
  endtask

  task automatic clear_grid();
    for (int r = 0; r < H; r++) write_row(r, '0);
  endtask

  // One generation; poke drives write/start while busy and in the done cycle,
  // sw applies a write in the same cycle as start.
  task automatic do_step(input string tag, input bit poke, input bit sw,
                         input int sw_r, input logic [W-1:0] sw_d);
    grid_t old_a, old_b;
    @(negedge clk);
    start = 1'b1;
    if (sw) begin
      wr_en = 1'b1; wr_row = RW'(sw_r); wr_data = sw_d;
      model_a[sw_r] = sw_d; model_b[sw_r] = sw_d;
    end
    old_a = model_a; old_b = model_b;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    chk({tag, "_busy_first"}, 32'(busy_a), 32'd1);
    chk({tag, "_done_first"}, 32'(done_a), 32'd0);
    for (int k = 1; k < H; k++) begin
      if (poke && k == 2) begin
        wr_en = 1'b1; wr_row = '0; wr_data = 8'hFF; start = 1'b1;
      end
      @(posedge clk); #1;
      wr_en = 1'b0; start = 1'b0;
      chk($sformatf("%s_busy_a_%0d", tag, k), 32'(busy_a), 32'd1);
      chk($sformatf("%s_busy_b_%0d", tag, k), 32'(busy_b), 32'd1);
    end
    @(posedge clk); #1;
    model_a = life_next(old_a, 1'b1, C_B, C_S);
    model_b = life_next(old_b, 1'b0, HL_B, C_S);
    gen_exp++;
    chk({tag, "_fin_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_fin_done_a"}, 32'(done_a), 32'd1);
    chk({tag, "_fin_done_b"}, 32'(done_b), 32'd1);
    chk({tag, "_gen_a"}, 32'(gen_a), 32'(gen_exp));
    chk({tag, "_gen_b"}, 32'(gen_b), 32'(gen_exp));
    chk({tag, "_still_a"}, 32'(still_a), 32'(model_a == old_a));
    chk({tag, "_still_b"}, 32'(still_b), 32'(model_b == old_b));
    if (poke) begin
      wr_en = 1'b1; wr_row = '0; wr_data = 8'hFF; start = 1'b1;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0;
    chk({tag, "_post_done"}, 32'(done_a), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_post_gen"}, 32'(gen_a), 32'(gen_exp));
  endtask

  initial begin
    logic [W-1:0] a, b;

    // Reset state
    #12;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_still", 32'(still_a), 32'd0);
    chk("rst_gen", 32'(gen_a), 32'd0);
    chk("rst_rd", 32'(rd_data_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    check_grid("reset");

    // Blinker: vertical -> horizontal -> vertical
    for (int r = 1; r <= 3; r++) write_row(r, 8'h08);
    do_step("blink1", 1'b0, 1'b0, 0, '0);
    read_row(2, a, b);
    chk("blink1_row2_a", 32'(a), 32'h1C);
    chk("blink1_row2_b", 32'(b), 32'h1C);
    read_row(1, a, b);
    chk("blink1_row1_a", 32'(a), 32'h00);
    do_step("blink2", 1'b0, 1'b0, 0, '0);
    check_grid("blink2");
    read_row(3, a, b);
    chk("blink2_row3_a", 32'(a), 32'h08);
    chk("blink2_gen", 32'(gen_a), 32'd2);

    // Block still life
    clear_grid();
    write_row(1, 8'h06); write_row(2, 8'h06);
    do_step("block", 1'b0, 1'b0, 0, '0);
    chk("block_still", 32'(still_a), 32'd1);
    check_grid("block");

    // Six-neighbour cell at (3,3): born under HighLife only
    clear_grid();
    write_row(2, 8'h1C); write_row(3, 8'h14); write_row(4, 8'h04);
    do_step("hl", 1'b0, 1'b0, 0, '0);
    read_row(3, a, b);
    chk("hl_b3s23_dead", 32'(a[3]), 32'd0);
    chk("hl_b36_born", 32'(b[3]), 32'd1);
    check_grid("hl");

    // Writes and starts while busy/FIN are ignored
    for (int r = 0; r < H; r++) write_row(r, W'($urandom));
    do_step("poke", 1'b1, 1'b0, 0, '0);
    check_grid("poke");

    // Write in the start cycle is seen by the step
    do_step("samecyc", 1'b0, 1'b1, 2, 8'h38);
    check_grid("samecyc");

    // Out-of-range row indices
    write_row(7, 8'hFF);
    read_row(6, a, b);
    chk("oor_rd6", 32'(a), 32'd0);
    read_row(7, a, b);
    chk("oor_rd7", 32'(b), 32'd0);
    check_grid("oor");

    // Random soups
    for (int t = 0; t < 4; t++) begin
      for (int r = 0; r < H; r++) write_row(r, W'($urandom));
      for (int s = 0; s < 3; s++) begin
        do_step($sformatf("rnd%0d_%0d", t, s), 1'b0, 1'b0, 0, '0);
        check_grid($sformatf("rnd%0d_%0d", t, s));
      end
    end

    // Reset mid-step
    for (int r = 0; r < H; r++) write_row(r, W'($urandom) | 8'h01);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    chk("mid_rst_gen", 32'(gen_a), 32'd0);
    chk("mid_rst_rd", 32'(rd_data_a), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    model_a = '0; model_b = '0; gen_exp = 0;
    check_grid("mid_rst");
    do_step("empty", 1'b0, 1'b0, 0, '0);
    chk("empty_still", 32'(still_b), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
